pkt_framer_gen: RTL and testbench
=================================

Name: pkt_framer_gen

Overview:
- Parametrised successor of the fixed 8-bit din/len/dout/cfg DUT.
- Buffers a byte stream (din) and a stream of packet lengths (len) in two independent FIFOs.
- An output FSM emits one framed packet per length entry on dout, optionally prefixed by a length header.
- A cfg register port provides control, status and wrapping statistics counters.

Parameters:
- DATA_W, 8, width of din/dout data.
- LEN_W, 8, width of len_value and packet length; must be <= DATA_W when the header is used.
- DATA_DEPTH, 16, data FIFO entries (power of 2, >=2).
- LEN_DEPTH, 4, length FIFO entries (power of 2, >=2).
- ADDR_W, 8, cfg address width.
- CFG_W, 32, cfg data width.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- din_value  in  DATA_W  data byte.
- din_en  in  1  push; legal only while din_rdy=1.
- din_rdy  out  1  data FIFO not full.
- len_value  in  LEN_W  packet length in bytes.
- len_en  in  1  push length; legal only while len_rdy=1.
- len_rdy  out  1  length FIFO not full.
- dout_en  in  1  pop; legal only while dout_rdy=1.
- dout_value  out  DATA_W  current output word; valid while dout_rdy=1.
- dout_rdy  out  1  output word available.
- cfg_address  in  ADDR_W  register address.
- cfg_data_in  in  CFG_W  write data.
- cfg_op  in  1  1=write, 0=read.
- cfg_en  in  1  cfg access strobe.
- cfg_data_out  out  CFG_W  read data for cfg_address (combinational).
- cfg_rdy  out  1  always 1 out of reset.

Behaviour:
- Reset (async, RST=1):
  - FIFOs empty; FSM in IDLE; counters 0; CTRL=0x1.
  - Outputs: din_rdy=0, len_rdy=0, dout_rdy=0, dout_value=0, cfg_rdy=0, cfg_data_out=0.
  - From the first CLK edge after RST deasserts: din_rdy=1, len_rdy=1, cfg_rdy=1.
- FIFOs:
  - Push visible at the head the cycle after the push edge.
  - Simultaneous push and pop allowed; occupancy unchanged.
  - din_rdy=0 at DATA_DEPTH entries; len_rdy=0 at LEN_DEPTH entries.
  - Pointers wrap modulo depth.
- FSM states: IDLE, HDR, BODY.
  - IDLE -> HDR when CTRL.en=1, len FIFO non-empty and CTRL.hdr=1; the length entry is popped into rem.
  - IDLE -> BODY under the same conditions with CTRL.hdr=0, provided len head != 0.
  - len head = 0 and CTRL.hdr=0: entry popped, ZERO_CNT+1, FSM stays in IDLE.
  - HDR:
    - dout_rdy=1, dout_value = zero-extended rem.
    - On dout_en: go to BODY if rem != 0, else IDLE; PKT_CNT+1 in the rem=0 case.
  - BODY:
    - dout_rdy = data FIFO non-empty; dout_value = data head.
    - Each dout_en pops one byte, rem-1, BYTE_CNT+1.
    - On the pop with rem=1: go to IDLE, PKT_CNT+1.
  - Minimum latency: len at edge N, data already present -> dout_rdy=1 after edge N+2.
  - CTRL.en=0 blocks only new packets; a packet in HDR/BODY completes.
  - dout_value=0 whenever dout_rdy=0.
- cfg map (word addresses):
  - 0x00 CTRL, RW: bit0 en, bit1 hdr; other bits read 0.
  - 0x01 STATUS, RO: [15:0] data occupancy, [23:16] len occupancy, [25:24] state (IDLE=0, HDR=1, BODY=2).
  - 0x02 PKT_CNT, 0x03 BYTE_CNT, 0x04 ZERO_CNT: any write clears; on the same edge as an increment, the clear wins.
  - Counters wrap at 2^CFG_W.
  - Writes take effect at the edge with cfg_en=1 and cfg_op=1.
  - Reads: cfg_data_out is combinational from cfg_address every cycle; a read with cfg_en has no side effects.
  - Unmapped addresses read 0; writes to them are ignored.
- Reset mid-packet: everything returns to reset values immediately; the partial packet is discarded.

Test Plan:
- Reset, then push din 0x11,0x22,0x33 and len 3 (CTRL=0x1) -> dout gives 0x11,0x22,0x33; PKT_CNT=1, BYTE_CNT=3, STATUS=0.
- Write CTRL=0x3, push len 2 and din 0xAA,0xBB -> dout gives 0x02,0xAA,0xBB; len 0 -> single 0x00 header, PKT_CNT+1.
- CTRL=0x1, push len 0 -> no dout_rdy, ZERO_CNT=1; then push len 1 and din 0x5C -> dout 0x5C.
- Fill the data FIFO with 16 bytes without popping -> din_rdy=0 with occupancy 16; a push and pop in the same cycle at 15 entries -> occupancy stays 15; read pointers wrap with correct order over 40 bytes.
- Write CTRL=0x0 in mid-BODY of a length-4 packet -> packet completes; next queued len is not started until CTRL=0x1.
- Assert RST mid-BODY -> all rdy signals drop to 0 immediately; after release, STATUS=0, counters 0, CTRL reads 0x1, and address 0x7F reads 0.

Source files
------------

// File: rtl/pkt_framer_gen.sv
// pkt_framer_gen: buffers a data stream and a length stream in two FIFOs and
// emits one framed packet per length entry, optionally led by a length header.
// A small cfg register port exposes control, status and statistics counters.
module pkt_framer_gen #(
   parameter int DATA_W     = 8,
   parameter int LEN_W      = 8,
   parameter int DATA_DEPTH = 16,
   parameter int LEN_DEPTH  = 4,
   parameter int ADDR_W     = 8,
   parameter int CFG_W      = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] din_value,
   input  logic              din_en,
   output logic              din_rdy,
   input  logic [LEN_W-1:0]  len_value,
   input  logic              len_en,
   output logic              len_rdy,
   input  logic              dout_en,
   output logic [DATA_W-1:0] dout_value,
   output logic              dout_rdy,
   input  logic [ADDR_W-1:0] cfg_address,
   input  logic [CFG_W-1:0]  cfg_data_in,
   input  logic              cfg_op,
   input  logic              cfg_en,
   output logic [CFG_W-1:0]  cfg_data_out,
   output logic              cfg_rdy
);
   localparam int DP_W = $clog2(DATA_DEPTH);
   localparam int DC_W = $clog2(DATA_DEPTH + 1);
   localparam int LP_W = $clog2(LEN_DEPTH);
   localparam int LC_W = $clog2(LEN_DEPTH + 1);

   localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_PKT    = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] A_BYTE   = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] A_ZERO   = ADDR_W'(4);

   typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, BODY = 2'd2} state_t;

   state_t            state_q;
   logic              load_q;
   logic [LEN_W-1:0]  rem_q;
   logic              rdy_q;
   logic [1:0]        ctrl_q;
   logic [CFG_W-1:0]  pkt_cnt_q, byte_cnt_q, zero_cnt_q;

   logic [DATA_W-1:0] d_mem [DATA_DEPTH];
   logic [DP_W-1:0]   d_wr_q, d_rd_q;
   logic [DC_W-1:0]   d_cnt_q;
   logic [LEN_W-1:0]  l_mem [LEN_DEPTH];
   logic [LP_W-1:0]   l_wr_q, l_rd_q;
   logic [LC_W-1:0]   l_cnt_q;

   logic              d_push, d_pop, l_push, l_pop;
   logic              hdr_done, pkt_inc, zero_inc, cfg_wr;
   logic [CFG_W-1:0]  rd_data_d;
   logic              unused_cfg_bits;

   assign unused_cfg_bits = ^cfg_data_in[CFG_W-1:2];

   assign cfg_rdy  = rdy_q;
   assign din_rdy  = rdy_q & (d_cnt_q != DC_W'(DATA_DEPTH));
   assign len_rdy  = rdy_q & (l_cnt_q != LC_W'(LEN_DEPTH));
   assign d_push   = din_en & din_rdy;
   assign l_push   = len_en & len_rdy;
   assign d_pop    = (state_q == BODY) & dout_en & (d_cnt_q != '0);
   // A length entry is only taken while idle with no decision pending.
   assign l_pop    = (state_q == IDLE) & ~load_q & ctrl_q[0] & (l_cnt_q != '0);
   assign hdr_done = (state_q == HDR) & dout_en;
   assign pkt_inc  = (hdr_done & (rem_q == '0)) | (d_pop & (rem_q == LEN_W'(1)));
   assign zero_inc = (state_q == IDLE) & load_q & ~ctrl_q[1] & (rem_q == '0);
   assign cfg_wr   = cfg_en & cfg_op;

   // Ready flag: outputs stay quiet until the first edge after reset release.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) rdy_q <= 1'b0;
      else     rdy_q <= 1'b1;
   end

   // Data FIFO storage (no reset on payload).
   always_ff @(posedge CLK) begin
      if (d_push) d_mem[d_wr_q] <= din_value;
   end

   // Data FIFO pointers and occupancy.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         d_wr_q  <= '0;
         d_rd_q  <= '0;
         d_cnt_q <= '0;
      end else begin
         if (d_push) d_wr_q <= d_wr_q + DP_W'(1);
         if (d_pop)  d_rd_q <= d_rd_q + DP_W'(1);
         d_cnt_q <= d_cnt_q + DC_W'(d_push) - DC_W'(d_pop);
      end
   end

   // Length FIFO storage.
   always_ff @(posedge CLK) begin
      if (l_push) l_mem[l_wr_q] <= len_value;
   end

   // Length FIFO pointers and occupancy.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         l_wr_q  <= '0;
         l_rd_q  <= '0;
         l_cnt_q <= '0;
      end else begin
         if (l_push) l_wr_q <= l_wr_q + LP_W'(1);
         if (l_pop)  l_rd_q <= l_rd_q + LP_W'(1);
         l_cnt_q <= l_cnt_q + LC_W'(l_push) - LC_W'(l_pop);
      end
   end

   // Framing FSM: a popped length is held one cycle in IDLE (load_q) before
   // the header/body/zero decision, giving a two-edge len-to-output latency.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         load_q  <= 1'b0;
         rem_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (load_q) begin
                  load_q <= 1'b0;
                  if (ctrl_q[1])         state_q <= HDR;
                  else if (rem_q != '0)  state_q <= BODY;
               end else if (l_pop) begin
                  load_q <= 1'b1;
                  rem_q  <= l_mem[l_rd_q];
               end
            end
            HDR: begin
               if (dout_en) state_q <= (rem_q == '0) ? IDLE : BODY;
            end
            BODY: begin
               if (d_pop) begin
                  rem_q <= rem_q - LEN_W'(1);
                  if (rem_q == LEN_W'(1)) state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Control register and statistics counters; a write clears a counter and
   // takes priority over a coincident increment.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ctrl_q     <= 2'b01;
         pkt_cnt_q  <= '0;
         byte_cnt_q <= '0;
         zero_cnt_q <= '0;
      end else begin
         if (cfg_wr && cfg_address == A_CTRL) ctrl_q <= cfg_data_in[1:0];
         if (cfg_wr && cfg_address == A_PKT)       pkt_cnt_q <= '0;
         else if (pkt_inc)                         pkt_cnt_q <= pkt_cnt_q + CFG_W'(1);
         if (cfg_wr && cfg_address == A_BYTE)      byte_cnt_q <= '0;
         else if (d_pop)                           byte_cnt_q <= byte_cnt_q + CFG_W'(1);
         if (cfg_wr && cfg_address == A_ZERO)      zero_cnt_q <= '0;
         else if (zero_inc)                        zero_cnt_q <= zero_cnt_q + CFG_W'(1);
      end
   end

   // Output word: header carries the length, body streams the data head.
   always_comb begin
      dout_rdy   = 1'b0;
      dout_value = '0;
      case (state_q)
         HDR: begin
            dout_rdy   = 1'b1;
            dout_value = DATA_W'(rem_q);
         end
         BODY: begin
            if (d_cnt_q != '0) begin
               dout_rdy   = 1'b1;
               dout_value = d_mem[d_rd_q];
            end
         end
         default: ;
      endcase
   end

   // Register read mux.
   always_comb begin
      rd_data_d = '0;
      case (cfg_address)
         A_CTRL:   rd_data_d[1:0] = ctrl_q;
         A_STATUS: begin
            rd_data_d[15:0]  = 16'(d_cnt_q);
            rd_data_d[23:16] = 8'(l_cnt_q);
            rd_data_d[25:24] = state_q;
         end
         A_PKT:    rd_data_d = pkt_cnt_q;
         A_BYTE:   rd_data_d = byte_cnt_q;
         A_ZERO:   rd_data_d = zero_cnt_q;
         default:  ;
      endcase
   end

   assign cfg_data_out = rdy_q ? rd_data_d : '0;

endmodule

// File: tb/tb_pkt_framer_gen.sv
// Bench for pkt_framer_gen: scenario tasks with an expected-stream model.
module tb_pkt_framer_gen;
   logic        CLK = 1'b0;
   logic        RST;
   logic [7:0]  din_value, len_value, dout_value;
   logic        din_en, len_en, dout_en;
   logic        din_rdy, len_rdy, dout_rdy;
   logic [7:0]  cfg_address;
   logic [31:0] cfg_data_in, cfg_data_out;
   logic        cfg_op, cfg_en, cfg_rdy;

   int errors = 0;
   int checks = 0;
   logic [7:0] got[$];
   logic [7:0] exp_q[$];

   always #5 CLK = ~CLK;

   pkt_framer_gen dut (
      .CLK(CLK), .RST(RST),
      .din_value(din_value), .din_en(din_en), .din_rdy(din_rdy),
      .len_value(len_value), .len_en(len_en), .len_rdy(len_rdy),
      .dout_en(dout_en), .dout_value(dout_value), .dout_rdy(dout_rdy),
      .cfg_address(cfg_address), .cfg_data_in(cfg_data_in), .cfg_op(cfg_op),
      .cfg_en(cfg_en), .cfg_data_out(cfg_data_out), .cfg_rdy(cfg_rdy)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
      cfg_address = a; cfg_data_in = d; cfg_op = 1'b1; cfg_en = 1'b1;
      tick();
      cfg_en = 1'b0; cfg_op = 1'b0;
   endtask

   task automatic cfg_read(input logic [7:0] a, output logic [31:0] d);
      cfg_address = a;
      #1;
      d = cfg_data_out;
   endtask

   task automatic push_din(input logic [7:0] b);
      int w = 0;
      while (!din_rdy && w < 200) begin tick(); w++; end
      if (!din_rdy) begin
         checks++; errors++;
         $display("FAIL din_wait: din_rdy=0 after %0d cycles, required 1", w);
         return;
      end
      din_value = b; din_en = 1'b1;
      tick();
      din_en = 1'b0;
   endtask

   task automatic push_len(input logic [7:0] l);
      int w = 0;
      while (!len_rdy && w < 200) begin tick(); w++; end
      if (!len_rdy) begin
         checks++; errors++;
         $display("FAIL len_wait: len_rdy=0 after %0d cycles, required 1", w);
         return;
      end
      len_value = l; len_en = 1'b1;
      tick();
      len_en = 1'b0;
   endtask

   task automatic pop_words(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         int w = 0;
         repeat ($urandom_range(0, gap)) tick();
         while (!dout_rdy && w < 200) begin tick(); w++; end
         if (!dout_rdy) begin
            checks++; errors++;
            $display("FAIL pop_wait: dout_rdy=0 after %0d cycles, required 1", w);
            return;
         end
         got.push_back(dout_value);
         dout_en = 1'b1;
         tick();
         dout_en = 1'b0;
      end
   endtask

   task automatic test_reset();
      logic [31:0] r;
      RST = 1'b1;
      repeat (3) tick();
      cfg_address = 8'h00;
      #1;
      checks++; if ({din_rdy, len_rdy, dout_rdy, cfg_rdy} !== 4'b0000) begin errors++;
         $display("FAIL rst_rdys: got %b required 0000", {din_rdy, len_rdy, dout_rdy, cfg_rdy}); end
      checks++; if (dout_value !== 8'h00) begin errors++;
         $display("FAIL rst_dout: got %h required 00", dout_value); end
      checks++; if (cfg_data_out !== 32'h0) begin errors++;
         $display("FAIL rst_cfg_out: got %h required 0", cfg_data_out); end
      RST = 1'b0;
      tick();
      checks++; if ({din_rdy, len_rdy, cfg_rdy, dout_rdy} !== 4'b1110) begin errors++;
         $display("FAIL post_rst_rdys: got %b required 1110", {din_rdy, len_rdy, cfg_rdy, dout_rdy}); end
      cfg_read(8'h00, r);
      checks++; if (r !== 32'h1) begin errors++; $display("FAIL rst_ctrl: got %h required 1", r); end
      cfg_read(8'h01, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL rst_status: got %h required 0", r); end
   endtask

   task automatic test_basic();
      logic [31:0] r;
      got.delete();
      exp_q = '{8'h11, 8'h22, 8'h33};
      foreach (exp_q[i]) push_din(exp_q[i]);
      push_len(8'd3);
      checks++; if (dout_rdy !== 1'b0) begin errors++; $display("FAIL lat_n0: dout_rdy got %b required 0", dout_rdy); end
      tick();
      checks++; if (dout_rdy !== 1'b0) begin errors++; $display("FAIL lat_n1: dout_rdy got %b required 0", dout_rdy); end
      tick();
      checks++; if (dout_rdy !== 1'b1) begin errors++; $display("FAIL lat_n2: dout_rdy got %b required 1", dout_rdy); end
      pop_words(3, 0);
      checks++; if (got.size() != exp_q.size()) begin errors++;
         $display("FAIL basic_count: got %0d words required %0d", got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         checks++; if (got[i] !== exp_q[i]) begin errors++;
            $display("FAIL basic_word%0d: got %h required %h", i, got[i], exp_q[i]); end
      end
      cfg_read(8'h02, r);
      checks++; if (r !== 32'd1) begin errors++; $display("FAIL basic_pkt: got %0d required 1", r); end
      cfg_read(8'h03, r);
      checks++; if (r !== 32'd3) begin errors++; $display("FAIL basic_byte: got %0d required 3", r); end
      cfg_read(8'h01, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL basic_status: got %h required 0", r); end
   endtask

   task automatic test_header();
      logic [31:0] r;
      got.delete();
      cfg_write(8'h00, 32'h3);
      push_len(8'd2);
      push_din(8'hAA);
      push_din(8'hBB);
      pop_words(3, 1);
      push_len(8'd0);
      pop_words(1, 0);
      exp_q = '{8'h02, 8'hAA, 8'hBB, 8'h00};
      checks++; if (got.size() != exp_q.size()) begin errors++;
         $display("FAIL hdr_count: got %0d words required %0d", got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         checks++; if (got[i] !== exp_q[i]) begin errors++;
            $display("FAIL hdr_word%0d: got %h required %h", i, got[i], exp_q[i]); end
      end
      repeat (3) tick();
      checks++; if (dout_rdy !== 1'b0) begin errors++; $display("FAIL hdr_idle: dout_rdy got %b required 0", dout_rdy); end
      cfg_read(8'h02, r);
      checks++; if (r !== 32'd3) begin errors++; $display("FAIL hdr_pkt: got %0d required 3", r); end
   endtask

   task automatic test_zero_len();
      logic [31:0] r;
      got.delete();
      cfg_write(8'h00, 32'h1);
      push_len(8'd0);
      for (int i = 0; i < 4; i++) begin
         checks++; if (dout_rdy !== 1'b0) begin errors++;
            $display("FAIL zero_quiet%0d: dout_rdy got %b required 0", i, dout_rdy); end
         tick();
      end
      cfg_read(8'h04, r);
      checks++; if (r !== 32'd1) begin errors++; $display("FAIL zero_cnt: got %0d required 1", r); end
      push_len(8'd1);
      push_din(8'h5C);
      pop_words(1, 0);
      checks++; if (got.size() != 1 || got[0] !== 8'h5C) begin errors++;
         $display("FAIL zero_next: got %0d words first %h required 1 word 5c", got.size(), got.size() ? got[0] : 8'h00); end
   endtask

   task automatic test_fifo_full();
      logic [31:0] r;
      logic [7:0] b;
      got.delete(); exp_q.delete();
      for (int i = 0; i < 16; i++) begin
         b = 8'($urandom); exp_q.push_back(b); push_din(b);
      end
      checks++; if (din_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy: din_rdy got %b required 0", din_rdy); end
      cfg_read(8'h01, r);
      checks++; if (r[15:0] !== 16'd16) begin errors++; $display("FAIL full_occ: got %0d required 16", r[15:0]); end
      push_len(8'd40);
      pop_words(1, 0);
      checks++; if (dout_rdy !== 1'b1) begin errors++; $display("FAIL sim_rdy: dout_rdy got %b required 1", dout_rdy); end
      got.push_back(dout_value);
      b = 8'($urandom); exp_q.push_back(b);
      din_value = b; din_en = 1'b1; dout_en = 1'b1;
      tick();
      din_en = 1'b0; dout_en = 1'b0;
      cfg_read(8'h01, r);
      checks++; if (r[15:0] !== 16'd15) begin errors++; $display("FAIL sim_occ: got %0d required 15", r[15:0]); end
      for (int i = 0; i < 23; i++) begin
         b = 8'($urandom); exp_q.push_back(b); push_din(b);
         pop_words(1, 0);
      end
      pop_words(15, 1);
      checks++; if (got.size() != exp_q.size()) begin errors++;
         $display("FAIL wrap_count: got %0d words required %0d", got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         checks++; if (got[i] !== exp_q[i]) begin errors++;
            $display("FAIL wrap_word%0d: got %h required %h", i, got[i], exp_q[i]); end
      end
   endtask

   task automatic test_ctrl_pause();
      logic [31:0] r;
      logic [7:0] b;
      got.delete(); exp_q.delete();
      cfg_write(8'h02, 32'h0);
      for (int i = 0; i < 4; i++) begin b = 8'($urandom); exp_q.push_back(b); push_din(b); end
      push_len(8'd4);
      pop_words(1, 0);
      cfg_write(8'h00, 32'h0);
      pop_words(3, 1);
      cfg_read(8'h01, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL pause_status: got %h required 0", r); end
      push_len(8'd2); push_len(8'd1); push_len(8'd1); push_len(8'd1);
      checks++; if (len_rdy !== 1'b0) begin errors++; $display("FAIL len_full: len_rdy got %b required 0", len_rdy); end
      for (int i = 0; i < 5; i++) begin b = 8'($urandom); exp_q.push_back(b); push_din(b); end
      repeat (5) tick();
      checks++; if (dout_rdy !== 1'b0) begin errors++; $display("FAIL pause_hold: dout_rdy got %b required 0", dout_rdy); end
      cfg_read(8'h01, r);
      checks++; if (r[23:16] !== 8'd4 || r[25:24] !== 2'd0) begin errors++;
         $display("FAIL pause_len_occ: got occ %0d state %0d required 4 and 0", r[23:16], r[25:24]); end
      cfg_write(8'h00, 32'h1);
      pop_words(5, 1);
      checks++; if (got.size() != exp_q.size()) begin errors++;
         $display("FAIL pause_count: got %0d words required %0d", got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         checks++; if (got[i] !== exp_q[i]) begin errors++;
            $display("FAIL pause_word%0d: got %h required %h", i, got[i], exp_q[i]); end
      end
      cfg_read(8'h02, r);
      checks++; if (r !== 32'd5) begin errors++; $display("FAIL pause_pkt: got %0d required 5", r); end
   endtask

   task automatic test_random();
      logic [31:0] r;
      logic [7:0] b;
      int exp_pkt = 0, exp_byte = 0, exp_zero = 0;
      got.delete(); exp_q.delete();
      cfg_write(8'h02, 32'h0); cfg_write(8'h03, 32'h0); cfg_write(8'h04, 32'h0);
      for (int p = 0; p < 10; p++) begin
         int hdr = $urandom_range(0, 1);
         int len = $urandom_range(0, 6);
         cfg_write(8'h00, hdr ? 32'h3 : 32'h1);
         if (hdr) exp_q.push_back(8'(len));
         for (int k = 0; k < len; k++) begin b = 8'($urandom); exp_q.push_back(b); push_din(b); end
         push_len(8'(len));
         pop_words(len + hdr, 2);
         exp_byte += len;
         if (hdr || len > 0) exp_pkt++; else exp_zero++;
         repeat (4) tick();
      end
      checks++; if (got.size() != exp_q.size()) begin errors++;
         $display("FAIL rnd_count: got %0d words required %0d", got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         checks++; if (got[i] !== exp_q[i]) begin errors++;
            $display("FAIL rnd_word%0d: got %h required %h", i, got[i], exp_q[i]); end
      end
      cfg_read(8'h02, r);
      checks++; if (r !== 32'(exp_pkt)) begin errors++; $display("FAIL rnd_pkt: got %0d required %0d", r, exp_pkt); end
      cfg_read(8'h03, r);
      checks++; if (r !== 32'(exp_byte)) begin errors++; $display("FAIL rnd_byte: got %0d required %0d", r, exp_byte); end
      cfg_read(8'h04, r);
      checks++; if (r !== 32'(exp_zero)) begin errors++; $display("FAIL rnd_zero: got %0d required %0d", r, exp_zero); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] r;
      got.delete();
      cfg_write(8'h00, 32'h1);
      for (int i = 0; i < 4; i++) push_din(8'(8'h40 + i));
      push_len(8'd4);
      pop_words(2, 0);
      RST = 1'b1;
      #1;
      checks++; if ({din_rdy, len_rdy, dout_rdy, cfg_rdy} !== 4'b0000) begin errors++;
         $display("FAIL mid_rst_rdys: got %b required 0000", {din_rdy, len_rdy, dout_rdy, cfg_rdy}); end
      checks++; if (dout_value !== 8'h00) begin errors++; $display("FAIL mid_rst_dout: got %h required 00", dout_value); end
      repeat (2) tick();
      RST = 1'b0;
      tick();
      cfg_read(8'h01, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL mid_status: got %h required 0", r); end
      for (int a = 2; a <= 4; a++) begin
         cfg_read(8'(a), r);
         checks++; if (r !== 32'h0) begin errors++; $display("FAIL mid_cnt%0d: got %0d required 0", a, r); end
      end
      cfg_read(8'h00, r);
      checks++; if (r !== 32'h1) begin errors++; $display("FAIL mid_ctrl: got %h required 1", r); end
      cfg_write(8'h7F, 32'hFFFF_FFFF);
      cfg_read(8'h7F, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL unmapped: got %h required 0", r); end
      cfg_read(8'h00, r);
      checks++; if (r !== 32'h1) begin errors++; $display("FAIL unmapped_wr: ctrl got %h required 1", r); end
   endtask

   initial begin
      RST = 1'b1;
      din_value = '0; din_en = 1'b0; len_value = '0; len_en = 1'b0; dout_en = 1'b0;
      cfg_address = '0; cfg_data_in = '0; cfg_op = 1'b0; cfg_en = 1'b0;
      test_reset();
      test_basic();
      test_header();
      test_zero_len();
      test_fifo_full();
      test_ctrl_pause();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end
endmodule
